// File: rtl/gfx_pixel_arb.sv
// Round-robin arbiter sharing one pixel-stream sink between NUM_REQ generators,
// with optional frame lock and a registered, full-throughput output stage.
module gfx_pixel_arb #(
  parameter int NUM_REQ    = 2,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int PIXEL_BITS = 12,
  parameter int LOCK_FRAME = 1,
  localparam int X_BITS    = $clog2(FB_WIDTH),
  localparam int Y_BITS    = $clog2(FB_HEIGHT),
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            in_pvalid,
  output logic [NUM_REQ-1:0]            in_pready,
  input  logic [NUM_REQ*X_BITS-1:0]     in_x,
  input  logic [NUM_REQ*Y_BITS-1:0]     in_y,
  input  logic [NUM_REQ*PIXEL_BITS-1:0] in_color,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic                          pvalid,
  input  logic                          pready,
  output logic [X_BITS-1:0]             x,
  output logic [Y_BITS-1:0]             y,
  output logic [PIXEL_BITS-1:0]         color,
  output logic                          last,
  output logic [NUM_REQ-1:0]            grant
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
  logic [GW-1:0]           r_gidx, w_gidx_nxt;
  logic [GW-1:0]           r_rr_ptr, w_rr_nxt;
  logic [GW-1:0]           w_pick, w_gidx_inc;
  logic [GW:0]             w_j;
  logic                    w_any, w_slot, w_accept, w_release;

  logic                    r_pvalid;
  logic [X_BITS-1:0]       r_x;
  logic [Y_BITS-1:0]       r_y;
  logic [PIXEL_BITS-1:0]   r_color;
  logic                    r_last;

  // Output register can take a beat if empty or draining this cycle.
  assign w_slot     = !r_pvalid || pready;
  assign w_accept   = (r_state == S_BUSY) && in_pvalid[r_gidx] && w_slot;
  assign w_release  = w_accept && ((LOCK_FRAME == 0) || in_last[r_gidx]);
  assign w_gidx_inc = (r_gidx == GW'(NUM_REQ-1)) ? '0 : r_gidx + 1'b1;

  // First valid requester at or after rr_ptr, cyclically.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_j    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_j >= (GW+1)'(NUM_REQ)) w_j = w_j - (GW+1)'(NUM_REQ);
      if (!w_any && in_pvalid[w_j[GW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_j[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_state_nxt = S_BUSY;
        w_grant_nxt = NUM_REQ'(1) << w_pick;
        w_gidx_nxt  = w_pick;
      end
      S_BUSY: if (w_release) begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_rr_nxt    = w_gidx_inc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_pready = '0;
    if (r_state == S_BUSY) in_pready[r_gidx] = w_slot;
    grant = r_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pvalid <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_color  <= '0;
      r_last   <= 1'b0;
    end else if (w_accept) begin
      r_pvalid <= 1'b1;
      r_x      <= in_x[r_gidx*X_BITS +: X_BITS];
      r_y      <= in_y[r_gidx*Y_BITS +: Y_BITS];
      r_color  <= in_color[r_gidx*PIXEL_BITS +: PIXEL_BITS];
      r_last   <= in_last[r_gidx];
    end else if (pready) begin
      r_pvalid <= 1'b0;
    end
  end

  assign pvalid = r_pvalid;
  assign x      = r_x;
  assign y      = r_y;
  assign color  = r_color;
  assign last   = r_last;

endmodule

// File: tb/tb_gfx_pixel_arb.sv
// Scoreboard bench for gfx_pixel_arb: per-requester beat queues, output
// ordering/stability checks, and a LOCK_FRAME=0 instance for per-beat rotation.
module tb_gfx_pixel_arb;
  localparam int NR = 2, XB = 10, YB = 9, PB = 12;

  typedef struct packed {
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [PB-1:0] c;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic [NR-1:0]    in_pvalid, in_pready, in_last, grant;
  logic [NR*XB-1:0] in_x;
  logic [NR*YB-1:0] in_y;
  logic [NR*PB-1:0] in_color;
  logic pvalid, pready, last;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [PB-1:0] color;

  logic l_rst_n;
  logic [NR-1:0]    l_in_pvalid, l_in_pready, l_in_last, l_grant;
  logic [NR*XB-1:0] l_in_x;
  logic [NR*YB-1:0] l_in_y;
  logic [NR*PB-1:0] l_in_color;
  logic l_pvalid, l_pready, l_last;
  logic [XB-1:0] l_x;
  logic [YB-1:0] l_y;
  logic [PB-1:0] l_color;

  gfx_pixel_arb #(.NUM_REQ(NR), .LOCK_FRAME(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_pvalid(in_pvalid), .in_pready(in_pready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_last(in_last),
    .pvalid(pvalid), .pready(pready), .x(x), .y(y), .color(color),
    .last(last), .grant(grant));

  gfx_pixel_arb #(.NUM_REQ(NR), .LOCK_FRAME(0)) u_dut_nl (
    .clk(clk), .reset_n(l_rst_n), .in_pvalid(l_in_pvalid), .in_pready(l_in_pready),
    .in_x(l_in_x), .in_y(l_in_y), .in_color(l_in_color), .in_last(l_in_last),
    .pvalid(l_pvalid), .pready(l_pready), .x(l_x), .y(l_y), .color(l_color),
    .last(l_last), .grant(l_grant));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  beat_t sq0[$], sq1[$], eq0[$], eq1[$];
  int    frame_order[$];
  int    out_cyc[$];
  logic  hold0 = 1'b0, rand_rdy = 1'b0, l_en = 1'b0;
  int    cyc = 0;

  task automatic push_frame(input int r, input int w, input int h);
    beat_t b;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        b.x = XB'(xx + 100 * r);
        b.y = YB'(yy + 7);
        b.c = {r[0], 11'($urandom)};
        b.l = (yy == h - 1) && (xx == w - 1);
        if (r == 0) begin sq0.push_back(b); eq0.push_back(b); end
        else        begin sq1.push_back(b); eq1.push_back(b); end
      end
  endtask

  // Input driver: each requester presents the head of its send queue.
  initial begin
    in_pvalid = '0; in_x = '0; in_y = '0; in_color = '0; in_last = '0; pready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pvalid[0] = (sq0.size() != 0) && !hold0;
      in_pvalid[1] = (sq1.size() != 0);
      if (sq0.size() != 0) begin
        in_x[0+:XB] = sq0[0].x; in_y[0+:YB] = sq0[0].y;
        in_color[0+:PB] = sq0[0].c; in_last[0] = sq0[0].l;
      end
      if (sq1.size() != 0) begin
        in_x[XB+:XB] = sq1[0].x; in_y[YB+:YB] = sq1[0].y;
        in_color[PB+:PB] = sq1[0].c; in_last[1] = sq1[0].l;
      end
    end
  end

  // Monitor on the falling edge, away from the active edge.
  logic  prev_stall = 1'b0, in_frame = 1'b0;
  int    owner = 0;
  beat_t held, got, e;
  logic [NR-1:0] l_exp_g = 2'b01;
  logic          l_exp_s = 1'b0;
  int            l_ngr = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0; in_frame = 1'b0;
    end else begin
      got = '{x: x, y: y, c: color, l: last};
      if (prev_stall) begin
        chk("hold_valid", 32'(pvalid), 32'd1);
        chk("hold_data", got, held);
      end
      if (pvalid && !pready) chk("rdy_full", 32'(in_pready), 32'd0);
      chk("gnt_1hot", 32'($countones(grant) <= 1), 32'd1);
      if (in_pvalid[0] && in_pready[0]) void'(sq0.pop_front());
      if (in_pvalid[1] && in_pready[1]) void'(sq1.pop_front());
      if (pvalid && pready) begin
        out_cyc.push_back(cyc);
        if (color[PB-1] == 1'b0 ? eq0.size() == 0 : eq1.size() == 0)
          chk("exp_empty", 32'd1, 32'd0);
        else begin
          e = (color[PB-1] == 1'b0) ? eq0.pop_front() : eq1.pop_front();
          chk("beat", got, e);
        end
        if (in_frame) chk("interleave", 32'(color[PB-1]), 32'(owner));
        owner = int'(color[PB-1]);
        in_frame = !last;
        if (last) frame_order.push_back(owner);
      end
      prev_stall = pvalid && !pready;
      held = got;
    end
    if (l_en) begin
      if (l_grant != '0) begin
        chk("nl_gnt", 32'(l_grant), 32'(l_exp_g));
        l_exp_g = {l_exp_g[0], l_exp_g[1]};
        l_ngr++;
      end
      if (l_pvalid && l_pready) begin
        chk("nl_src", 32'(l_color[0]), 32'(l_exp_s));
        l_exp_s = ~l_exp_s;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    frame_order.delete(); out_cyc.delete();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((sq0.size() != 0 || sq1.size() != 0 || eq0.size() != 0 ||
            eq1.size() != 0 || pvalid) && n < max_cyc) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", 32'(n < max_cyc), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_order(input string tag, input int n_frames);
    chk({tag, "_nfr"}, 32'(frame_order.size()), 32'(n_frames));
    for (int i = 0; i < frame_order.size() && i < n_frames; i++)
      chk(tag, 32'(frame_order[i]), 32'(i % 2));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    l_rst_n = 1'b0;
    l_in_pvalid = 2'b11; l_in_x = '0; l_in_y = '0; l_in_last = '0; l_pready = 1'b1;
    l_in_color = {12'd1, 12'd0};
    repeat (3) @(negedge clk);
    chk("rst_pvalid", 32'(pvalid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_inrdy", 32'(in_pready), 32'd0);
    chk("rst_data", {x, y, color, last}, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Single requester, 4x2 frame, sink always ready.
    @(posedge clk); #2 push_frame(0, 4, 2);
    @(posedge clk); @(negedge clk);
    chk("arb_idle", 32'(grant), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("arb_grant", 32'(grant), 32'b01);
    wait_drain(100);
    chk("t2_nbeats", 32'(out_cyc.size()), 32'd8);
    if (out_cyc.size() == 8) chk("t2_b2b", 32'(out_cyc[7] - out_cyc[0]), 32'd7);
    chk("t2_release", 32'(grant), 32'd0);
    chk_order("t2_order", 1);

    // Both requesting with frame lock: whole frames alternate.
    do_reset();
    push_frame(0, 2, 2); push_frame(1, 3, 1);
    push_frame(0, 2, 2); push_frame(1, 3, 1);
    wait_drain(200);
    chk_order("t3_order", 4);

    // Owner stalls mid-frame while the other requester waits.
    do_reset();
    push_frame(0, 4, 2); push_frame(1, 2, 1);
    n = 0;
    while (sq0.size() > 5 && n < 100) begin @(posedge clk); n++; end
    chk("t6_start_to", 32'(n < 100), 32'd1);
    #2 hold0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_gnt", 32'(grant), 32'b01);
    end
    @(posedge clk); #2 hold0 = 1'b0;
    wait_drain(200);
    chk_order("t6_order", 2);

    // Random backpressure with several frames per requester.
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(0, $urandom_range(1, 6), $urandom_range(1, 3));
      push_frame(1, $urandom_range(1, 6), $urandom_range(1, 3));
    end
    wait_drain(3000);
    chk_order("t5_order", 6);
    rand_rdy = 1'b0;

    // Per-beat rotation on the unlocked instance.
    @(posedge clk); #2 l_rst_n = 1'b1; l_en = 1'b1;
    repeat (20) @(posedge clk);
    #2 l_en = 1'b0;
    chk("nl_ngrants", 32'(l_ngr >= 8), 32'd1);

    // Reset asserted mid-frame clears outputs at once.
    do_reset();
    push_frame(0, 4, 4); push_frame(1, 2, 2);
    n = 0;
    while (out_cyc.size() < 3 && n < 100) begin @(posedge clk); n++; end
    chk("t1_start_to", 32'(n < 100), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_pvalid", 32'(pvalid), 32'd0);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_inrdy", 32'(in_pready), 32'd0);
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_post_pvalid", 32'(pvalid), 32'd0);
    chk("t1_post_grant", 32'(grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
